// File: rtl/n64_bank_responder.sv
// n64_bank_responder: runs PI bank accesses on the shared bus, with a one-word read-ahead buffer.
module n64_bank_responder #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_address,
    input  logic [3:0]        i_req_bank,
    input  logic              i_req_prefetch,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    input  logic              i_flush,
    output logic              o_mem_request,
    input  logic              i_mem_ack,
    output logic              o_mem_write,
    output logic [3:0]        o_mem_bank,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, MEM_WAIT, RESPOND, PF_WAIT} state_t;
    localparam logic [15:0] TO = 16'(TIMEOUT);
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic wr_q, wr_d, pf_q, pf_d, err_q, err_d, drop_q, drop_d, bv_q, bv_d;
    logic [3:0] bank_q, bank_d, bb_q, bb_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ba_q, ba_d, req_addr, pf_addr;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, bd_q, bd_d;
    logic hit, expired;
    assign req_addr = i_req_address & ~ADDR_W'(1);
    assign pf_addr  = addr_q + ADDR_W'(2);
    assign hit      = !i_req_write && i_req_bank != 4'd0 && bv_q && i_req_bank == bb_q && req_addr == ba_q;
    assign expired  = cnt_q == TO;
    assign o_req_ready   = state_q == IDLE;
    assign o_rsp_valid   = state_q == RESPOND;
    assign o_rsp_error   = o_rsp_valid && err_q;
    assign o_rsp_rdata   = o_rsp_valid ? rdata_q : '0;
    assign o_mem_request = state_q == MEM_WAIT || state_q == PF_WAIT;
    assign o_mem_write   = state_q == MEM_WAIT && wr_q;
    assign o_mem_bank    = o_mem_request ? bank_q : 4'd0;
    assign o_mem_address = state_q == MEM_WAIT ? addr_q : state_q == PF_WAIT ? pf_addr : '0;
    assign o_mem_wdata   = o_mem_write ? wdata_q : '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        wr_d    = wr_q;
        pf_d    = pf_q;
        err_d   = err_q;
        drop_d  = drop_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        bv_d    = bv_q;
        bb_d    = bb_q;
        ba_d    = ba_q;
        bd_d    = bd_q;
        case (state_q)
            IDLE: if (i_req_valid) begin
                wr_d    = i_req_write;
                pf_d    = i_req_prefetch;
                bank_d  = i_req_bank;
                addr_d  = req_addr;
                wdata_d = i_req_wdata;
                err_d   = i_req_bank == 4'd0;
                rdata_d = hit ? bd_q : '0;
                state_d = (i_req_bank == 4'd0 || hit) ? RESPOND : MEM_WAIT;
                // any real read consumes or supersedes the buffer; writes only hit their own bank
                if (i_req_bank != 4'd0 && (!i_req_write || i_req_bank == bb_q)) bv_d = 1'b0;
            end
            MEM_WAIT: if (i_mem_ack) begin
                state_d = RESPOND;
                rdata_d = wr_q ? '0 : i_mem_rdata;
            end else if (expired) begin
                state_d = RESPOND;
                err_d   = 1'b1;
                rdata_d = '0;
            end else cnt_d = cnt_q + 16'd1;
            RESPOND: begin
                state_d = (!wr_q && pf_q && !err_q) ? PF_WAIT : IDLE;
                drop_d  = 1'b0;
            end
            PF_WAIT: begin
                drop_d = drop_q || i_flush;
                if (i_mem_ack) begin
                    state_d = IDLE;
                    if (!drop_q) begin
                        bv_d = 1'b1;
                        bb_d = bank_q;
                        ba_d = pf_addr;
                        bd_d = i_mem_rdata;
                    end
                end else if (expired) state_d = IDLE;
                else cnt_d = cnt_q + 16'd1;
            end
        endcase
        if (i_flush) bv_d = 1'b0;
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            pf_q    <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            bv_q    <= 1'b0;
            bb_q    <= '0;
            ba_q    <= '0;
            bd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            pf_q    <= pf_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            bv_q    <= bv_d;
            bb_q    <= bb_d;
            ba_q    <= ba_d;
            bd_q    <= bd_d;
        end
    end
endmodule

// File: tb/tb_n64_bank_responder.sv
// tb_n64_bank_responder: directed scenario tests for n64_bank_responder with TIMEOUT=4.
module tb_n64_bank_responder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_prefetch = 1'b0, flush = 1'b0;
    logic        mem_ack = 1'b0;
    logic [25:0] req_address = '0;
    logic [3:0]  req_bank = '0;
    logic [15:0] req_wdata = '0, mem_rdata = '0;
    logic        req_ready, rsp_valid, rsp_error, mem_request, mem_write;
    logic [15:0] rsp_rdata, mem_wdata;
    logic [3:0]  mem_bank;
    logic [25:0] mem_address;
    int checks = 0, errors = 0;

    n64_bank_responder #(.ADDR_W(26), .DATA_W(16), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_address(req_address), .i_req_bank(req_bank), .i_req_prefetch(req_prefetch),
        .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_error(rsp_error), .i_flush(flush), .o_mem_request(mem_request),
        .i_mem_ack(mem_ack), .o_mem_write(mem_write), .o_mem_bank(mem_bank),
        .o_mem_address(mem_address), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic wr, input logic [25:0] a, input logic [3:0] b, input logic pf, input logic [15:0] wd);
        req_valid = 1'b1; req_write = wr; req_address = a; req_bank = b; req_prefetch = pf; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_bank = '0; req_prefetch = 1'b0; req_wdata = '0;
    endtask

    task automatic ack_with(input logic [15:0] d);
        mem_ack = 1'b1; mem_rdata = d;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset;
        tick(2);
        checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_rdata, mem_request, mem_write, mem_bank, mem_address, mem_wdata} !== {1'b1, 66'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h exp %h", {req_ready, rsp_valid, rsp_error, rsp_rdata, mem_request, mem_write, mem_bank, mem_address, mem_wdata}, {1'b1, 66'd0});
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_rom_read_prefetch;
        send(1'b0, 26'h100, 4'd1, 1'b1, 16'h0);
        checks++;
        if ({req_ready, mem_request, mem_write, mem_bank, mem_address} !== {1'b0, 1'b1, 1'b0, 4'd1, 26'h100}) begin
            errors++;
            $display("FAIL rom_bus_read: got %h exp %h", {req_ready, mem_request, mem_write, mem_bank, mem_address}, {1'b0, 1'b1, 1'b0, 4'd1, 26'h100});
        end
        tick(2);
        ack_with(16'h1234);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, mem_request} !== {1'b1, 1'b0, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL rom_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata, mem_request}, {1'b1, 1'b0, 16'h1234, 1'b0});
        end
        tick(1);
        checks++;
        if ({rsp_valid, mem_request, mem_write, mem_bank, mem_address} !== {1'b0, 1'b1, 1'b0, 4'd1, 26'h102}) begin
            errors++;
            $display("FAIL rom_prefetch_bus: got %h exp %h", {rsp_valid, mem_request, mem_write, mem_bank, mem_address}, {1'b0, 1'b1, 1'b0, 4'd1, 26'h102});
        end
        ack_with(16'h5678);
        checks++;
        if ({req_ready, mem_request} !== 2'b10) begin
            errors++;
            $display("FAIL prefetch_done_idle: got %b exp 10", {req_ready, mem_request});
        end
        send(1'b0, 26'h102, 4'd1, 1'b1, 16'h0);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, mem_request} !== {1'b1, 1'b0, 16'h5678, 1'b0}) begin
            errors++;
            $display("FAIL rom_hit_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata, mem_request}, {1'b1, 1'b0, 16'h5678, 1'b0});
        end
        tick(1);
        checks++;
        if ({mem_request, mem_address} !== {1'b1, 26'h104}) begin
            errors++;
            $display("FAIL hit_prefetch_addr: got %h exp %h", {mem_request, mem_address}, {1'b1, 26'h104});
        end
        ack_with(16'hAAAA);
    endtask

    task automatic test_invalid_bank;
        send(1'b0, 26'h104, 4'd0, 1'b1, 16'h0);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, mem_request} !== {1'b1, 1'b1, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL invalid_bank_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata, mem_request}, {1'b1, 1'b1, 16'h0, 1'b0});
        end
        tick(1);
        checks++;
        if ({rsp_valid, req_ready, mem_request} !== 3'b010) begin
            errors++;
            $display("FAIL invalid_bank_idle: got %b exp 010", {rsp_valid, req_ready, mem_request});
        end
    endtask

    task automatic test_write;
        send(1'b1, 26'h10, 4'd2, 1'b0, 16'hBEEF);
        checks++;
        if ({mem_request, mem_write, mem_bank, mem_address, mem_wdata} !== {1'b1, 1'b1, 4'd2, 26'h10, 16'hBEEF}) begin
            errors++;
            $display("FAIL write_bus: got %h exp %h", {mem_request, mem_write, mem_bank, mem_address, mem_wdata}, {1'b1, 1'b1, 4'd2, 26'h10, 16'hBEEF});
        end
        ack_with(16'hDEAD);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL write_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 16'h0});
        end
        tick(1);
        checks++;
        if ({mem_request, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL write_no_prefetch: got %b exp 01", {mem_request, req_ready});
        end
        send(1'b0, 26'h104, 4'd1, 1'b1, 16'h0);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, mem_request} !== {1'b1, 1'b0, 16'hAAAA, 1'b0}) begin
            errors++;
            $display("FAIL rom_buf_survives_cart_write: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata, mem_request}, {1'b1, 1'b0, 16'hAAAA, 1'b0});
        end
        tick(1);
        ack_with(16'h1111);
        send(1'b0, 26'h20, 4'd2, 1'b1, 16'h0);
        ack_with(16'h2222);
        tick(1);
        ack_with(16'h3333);
        send(1'b1, 26'h10, 4'd2, 1'b0, 16'hBEEF);
        ack_with(16'h0);
        tick(1);
        send(1'b0, 26'h22, 4'd2, 1'b1, 16'h0);
        checks++;
        if ({rsp_valid, mem_request, mem_address} !== {1'b0, 1'b1, 26'h22}) begin
            errors++;
            $display("FAIL cart_buf_invalidated: got %h exp %h", {rsp_valid, mem_request, mem_address}, {1'b0, 1'b1, 26'h22});
        end
        ack_with(16'h4444);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 16'h4444}) begin
            errors++;
            $display("FAIL cart_miss_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 16'h4444});
        end
        tick(1);
        ack_with(16'h0);
    endtask

    task automatic test_timeout;
        send(1'b0, 26'h200, 4'd1, 1'b1, 16'h0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_request !== 1'b1) begin
                errors++;
                $display("FAIL timeout_req_held[%0d]: got %b exp 1", i, mem_request);
            end
            tick(1);
        end
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, mem_request} !== {1'b1, 1'b1, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata, mem_request}, {1'b1, 1'b1, 16'h0, 1'b0});
        end
        tick(1);
        checks++;
        if ({mem_request, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_no_prefetch: got %b exp 01", {mem_request, req_ready});
        end
        send(1'b0, 26'h300, 4'd1, 1'b0, 16'h0);
        tick(4);
        checks++;
        if (mem_request !== 1'b1) begin
            errors++;
            $display("FAIL expiry_req_held: got %b exp 1", mem_request);
        end
        ack_with(16'h9ABC);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, mem_request} !== {1'b1, 1'b0, 16'h9ABC, 1'b0}) begin
            errors++;
            $display("FAIL ack_on_expiry_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata, mem_request}, {1'b1, 1'b0, 16'h9ABC, 1'b0});
        end
        tick(1);
        checks++;
        if ({mem_request, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL no_pf_idle: got %b exp 01", {mem_request, req_ready});
        end
    endtask

    task automatic test_wrap_flush;
        send(1'b0, 26'h3FFFFFE, 4'd1, 1'b1, 16'h0);
        checks++;
        if ({mem_request, mem_address} !== {1'b1, 26'h3FFFFFE}) begin
            errors++;
            $display("FAIL wrap_read_addr: got %h exp %h", {mem_request, mem_address}, {1'b1, 26'h3FFFFFE});
        end
        ack_with(16'h0F0F);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 16'h0F0F}) begin
            errors++;
            $display("FAIL wrap_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 16'h0F0F});
        end
        tick(1);
        checks++;
        if ({mem_request, mem_address} !== {1'b1, 26'h0}) begin
            errors++;
            $display("FAIL wrap_prefetch_addr: got %h exp %h", {mem_request, mem_address}, {1'b1, 26'h0});
        end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        ack_with(16'h5555);
        send(1'b0, 26'h0, 4'd1, 1'b1, 16'h0);
        checks++;
        if ({rsp_valid, mem_request, mem_address} !== {1'b0, 1'b1, 26'h0}) begin
            errors++;
            $display("FAIL flush_forces_miss: got %h exp %h", {rsp_valid, mem_request, mem_address}, {1'b0, 1'b1, 26'h0});
        end
        ack_with(16'h6666);
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 16'h6666}) begin
            errors++;
            $display("FAIL flush_miss_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 16'h6666});
        end
        tick(1);
        ack_with(16'h7777);
    endtask

    task automatic test_reset_mid;
        send(1'b1, 26'h400, 4'd3, 1'b0, 16'h1234);
        checks++;
        if ({mem_request, mem_write, mem_bank} !== {1'b1, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL eeprom_write_bus: got %h exp %h", {mem_request, mem_write, mem_bank}, {1'b1, 1'b1, 4'd3});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_request, req_ready, rsp_valid} !== 3'b010) begin
            errors++;
            $display("FAIL async_reset_drop: got %b exp 010", {mem_request, req_ready, rsp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if ({rsp_valid, mem_request, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL after_reset_idle: got %b exp 001", {rsp_valid, mem_request, req_ready});
        end
        send(1'b0, 26'h2, 4'd1, 1'b1, 16'h0);
        checks++;
        if ({rsp_valid, mem_request, mem_address} !== {1'b0, 1'b1, 26'h2}) begin
            errors++;
            $display("FAIL reset_clears_buffer: got %h exp %h", {rsp_valid, mem_request, mem_address}, {1'b0, 1'b1, 26'h2});
        end
    endtask

    initial begin
        test_reset;
        test_rom_read_prefetch;
        test_invalid_bank;
        test_write;
        test_timeout;
        test_wrap_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/n64_bank_responder.md
Name: n64_bank_responder

Overview:
Bank-side responder for N64 PI accesses. It takes requests already tagged with bank, translated address and prefetch flag by the PI address decode, and runs the access on the shared bank memory bus. Reads from prefetch-enabled banks are served from a one-word read-ahead buffer when possible. The block sits between the PI front end and the ROM/CART/EEPROM bank devices.

Parameters:
ADDR_W, 26, translated byte-address width
DATA_W, 16, PI data word width
TIMEOUT, 255, max cycles to wait for i_mem_ack before abort (1..65535)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  async active-low reset
i_req_valid  in  1  request present
o_req_ready  out  1  request accepted when valid&ready
i_req_write  in  1  1=write, 0=read
i_req_address  in  ADDR_W  translated byte address
i_req_bank  in  4  0=INVALID, 1=ROM, 2=CART, 3=EEPROM
i_req_prefetch  in  1  bank allows read-ahead
i_req_wdata  in  DATA_W  write data
o_rsp_valid  out  1  one-cycle response strobe
o_rsp_rdata  out  DATA_W  read data (0 for writes/errors)
o_rsp_error  out  1  invalid bank or timeout; valid with o_rsp_valid
i_flush  in  1  invalidate prefetch buffer
o_mem_request  out  1  bank bus request, held until ack
i_mem_ack  in  1  bank bus completion
o_mem_write  out  1  bus direction
o_mem_bank  out  4  target bank
o_mem_address  out  ADDR_W  bus address, bit 0 forced 0
o_mem_wdata  out  DATA_W  write data
i_mem_rdata  in  DATA_W  read data, valid on ack cycle

Behaviour:
- Clock i_clk; reset i_reset_n is asynchronous, active-low. Reset state: FSM IDLE, buffer invalid, timeout counter 0. All outputs 0 except o_req_ready=1.
- FSM states: IDLE, MEM_WAIT, RESPOND, PF_WAIT.
- o_req_ready=1 only in IDLE. Requests are captured on accept (cycle 0), with address bit 0 cleared.
- Invalid bank (0): no bus access. Cycle 1: o_rsp_valid=1, o_rsp_error=1, rdata=0. Back to IDLE.
- Read hit: buffer valid, bank equal and address equal. Cycle 1: o_rsp_valid with buffer data, error=0. Buffer is consumed (invalid). Then PF_WAIT issues a prefetch at address+2.
- Read miss, or any write: MEM_WAIT from cycle 1 with o_mem_* driven and o_mem_request=1. o_mem_request and o_mem_* stay stable until i_mem_ack is sampled high. i_mem_rdata is captured on the ack cycle. RESPOND in the next cycle: o_rsp_valid=1. After RESPOND:
  - read with i_req_prefetch=1 goes to PF_WAIT;
  - otherwise goes to IDLE.
- Writes never prefetch. A write invalidates the buffer if its bank equals the buffer bank.
- PF_WAIT drives a read at captured address+2, with o_mem_request starting the cycle after o_rsp_valid. On ack, store bank, address+2 and data, mark the buffer valid, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0x3FFFFFE+2 prefetches 0x0000000.
- Timeout: the counter clears on entry to MEM_WAIT/PF_WAIT and increments each cycle without ack. When the count reaches TIMEOUT without ack, o_mem_request drops next cycle:
  - MEM_WAIT: RESPOND with error=1, rdata=0.
  - PF_WAIT: return to IDLE silently with the buffer invalid.
- If ack arrives in the same cycle the count reaches TIMEOUT, ack wins.
- i_flush (any state) clears the buffer valid flag that cycle. If asserted during PF_WAIT, the prefetch completes on the bus but its data is discarded. If flush and prefetch-store coincide, flush wins.
- A miss whose address differs from the buffer address leaves the buffer invalid (replaced by the subsequent prefetch).
- Async reset mid-transfer drops o_mem_request immediately. No response is issued for the aborted request.

Test Plan:
- ROM read 0x0000100, ack after 3 cycles, rdata 0x1234 -> rsp_valid 1 cycle after ack with 0x1234, then mem read at 0x0000102. A second request at 0x0000102 after the prefetch completes -> rsp_valid at cycle 1 with no bus request.
- Bank 0 request -> rsp_valid at cycle 1, error=1, rdata 0, o_mem_request never high.
- CART write 0x0000010 data 0xBEEF -> one bus write (o_mem_write=1), response error=0, no prefetch. A ROM buffer valid beforehand stays valid; a CART buffer valid beforehand is invalidated.
- No ack, TIMEOUT=4 -> o_mem_request high 5 cycles, then rsp error=1. Ack on exactly the expiry cycle -> normal response with data.
- Read at 0x3FFFFFE on ROM -> prefetch address 0x0000000. i_flush during PF_WAIT -> a following read at 0 misses and goes to the bus.
- Reset asserted during MEM_WAIT -> o_mem_request low asynchronously, o_req_ready=1, buffer invalid, no rsp_valid.
